// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_pkg
//  Description : Shared constants for the seven-segment scan controller:
//                per-digit field layout of the frame word, the blank segment
//                pattern and a helper that sizes counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

  // Layout of one digit inside frame_data: {en, hex[3:0], dp}
  localparam int DIG_W   = 6;
  localparam int EN_BIT  = 5;
  localparam int HEX_MSB = 4;
  localparam int HEX_LSB = 1;
  localparam int DP_BIT  = 0;

  // Active-low segments: all ones turns every segment off
  localparam logic [6:0] SSEG_BLANK = 7'h7F;

  // Width of a counter that must hold 0..n-1 (at least one bit)
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex2sseg.sv
`default_nettype none
// ============================================================================
//  Module      : hex2sseg
//  Description : Hex nibble to seven-segment decoder, active-low, gfedcba.
//  Ports       : hex - nibble to display
//                seg - segment pattern, bit 6 = g ... bit 0 = a, 0 = lit
//  Revision    : 1.0 - initial release
// ============================================================================
module hex2sseg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_scan_ctrl
//  Description : Multiplexed common-anode seven-segment scan controller with
//                double-buffered frame, PWM brightness, per-digit blink,
//                leading-zero suppression and tear-free frame swap.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                frame_data/valid/ready - frame handshake into shadow buffer
//                brightness         - PWM duty, 0 = dark, all ones = full
//                blink_mask         - digits blanked during blink phase 1
//                lz_suppress        - enable leading-zero blanking
//                frame_start        - pulse while digit 0 dwell begins
//                AN, sseg, DP       - registered active-low pin drives
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int CLOCK_HZ    = 100_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int BRIGHT_BITS = 4,
  parameter int BLINK_HZ    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DIG_W*NUM_DIGITS-1:0] frame_data,
  input  logic                        frame_valid,
  output logic                        frame_ready,
  input  logic [BRIGHT_BITS-1:0]      brightness,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  input  logic                        lz_suppress,
  output logic                        frame_start,
  output logic [NUM_DIGITS-1:0]       AN,
  output logic [6:0]                  sseg,
  output logic                        DP
);

  localparam int DWELL   = CLOCK_HZ / SCAN_HZ;
  localparam int HALF    = CLOCK_HZ / (2 * BLINK_HZ);
  localparam int DWELL_W = cnt_w(DWELL);
  localparam int HALF_W  = cnt_w(HALF);
  localparam int IDX_W   = cnt_w(NUM_DIGITS);

  localparam logic [DWELL_W-1:0]     DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [HALF_W-1:0]      HALF_LAST  = HALF_W'(HALF - 1);
  localparam logic [IDX_W-1:0]       IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_BITS-1:0] PWM_LAST   = BRIGHT_BITS'((1 << BRIGHT_BITS) - 2);

  // run is low while reset is held and rises on the first cycle after
  // release; counters stay frozen until then so the scan always starts at
  // digit 0, dwell 0 on that cycle.
  logic                                run;
  logic [NUM_DIGITS-1:0][DIG_W-1:0]    shadow;
  logic [NUM_DIGITS-1:0][DIG_W-1:0]    active;
  logic                                shadow_full;
  logic [DWELL_W-1:0]                  dwell;
  logic [IDX_W-1:0]                    idx;
  logic [BRIGHT_BITS-1:0]              pwm;
  logic [HALF_W-1:0]                   blink_cnt;
  logic                                blink_phase;

  logic                                dwell_end;
  logic                                frame_end;
  logic                                capture;
  logic [DIG_W-1:0]                    cur;
  logic [6:0]                          seg_dec;
  logic [NUM_DIGITS-1:0]               lz_blank;
  logic                                leading;
  logic [NUM_DIGITS-1:0]               an_sel;
  logic                                lit;

  assign frame_ready = run & ~shadow_full;
  assign frame_start = run && (idx == '0) && (dwell == '0);
  assign dwell_end   = (dwell == DWELL_LAST);
  assign frame_end   = run && dwell_end && (idx == IDX_LAST);
  assign capture     = frame_valid && frame_ready;
  assign cur         = active[idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      run         <= 1'b0;
      shadow      <= '0;
      active      <= '0;
      shadow_full <= 1'b0;
      dwell       <= '0;
      idx         <= '0;
      pwm         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      run <= 1'b1;
      // Capture requires an empty shadow and swap a full one, so the two
      // branches are mutually exclusive by construction.
      if (capture) begin
        shadow      <= frame_data;
        shadow_full <= 1'b1;
      end else if (frame_end && shadow_full) begin
        active      <= shadow;
        shadow_full <= 1'b0;
      end
      if (run) begin
        dwell <= dwell_end ? '0 : dwell + 1'b1;
        if (dwell_end) begin
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        // Restarting the PWM during the guard cycle makes every digit see
        // the same on/off pattern from its first visible cycle.
        pwm <= ((dwell == '0) || (pwm == PWM_LAST)) ? '0 : pwm + 1'b1;
        if (blink_cnt == HALF_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Leading-zero run from the most significant digit down; disabled digits
  // are transparent to the run, digit 0 is never blanked.
  always_comb begin
    lz_blank = '0;
    leading  = lz_suppress;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (active[k][EN_BIT]) begin
        if (leading && (active[k][HEX_MSB:HEX_LSB] == 4'd0) && !active[k][DP_BIT]) begin
          lz_blank[k] = 1'b1;
        end else begin
          leading = 1'b0;
        end
      end
    end
  end

  always_comb begin
    an_sel = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        an_sel[k] = 1'b0;
      end
    end
  end

  hex2sseg u_dec (
    .hex (cur[HEX_MSB:HEX_LSB]),
    .seg (seg_dec)
  );

  // Dwell cycle 0 is the ghost guard: anodes stay off while the segment
  // lines settle onto the new digit.
  assign lit = run
            && (dwell != '0)
            && cur[EN_BIT]
            && !lz_blank[idx]
            && !(blink_mask[idx] && blink_phase)
            && (pwm < brightness);

  always_ff @(posedge clk) begin
    if (reset || !lit) begin
      AN   <= '1;
      sseg <= SSEG_BLANK;
      DP   <= 1'b1;
    end else begin
      AN   <= an_sel;
      sseg <= seg_dec;
      DP   <= ~cur[DP_BIT];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sseg_scan_ctrl
//  Description : Directed self-checking bench for sseg_scan_ctrl with
//                NUM_DIGITS=4, DWELL=10, BRIGHT_BITS=2, HALF=100.
//                cyc counts cycles from reset release (cyc 0 = first cycle
//                after release); pins observed at cyc reflect state cyc-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_ctrl;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [6*N-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ready;
  logic [1:0]    brightness;
  logic [N-1:0]  blink_mask;
  logic          lz_suppress;
  logic          frame_start;
  logic [N-1:0]  AN;
  logic [6:0]    sseg;
  logic          DP;

  int cyc;
  int n_checks;
  int n_pass;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .CLOCK_HZ    (1000),
    .SCAN_HZ     (100),
    .BRIGHT_BITS (2),
    .BLINK_HZ    (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .brightness  (brightness),
    .blink_mask  (blink_mask),
    .lz_suppress (lz_suppress),
    .frame_start (frame_start),
    .AN          (AN),
    .sseg        (sseg),
    .DP          (DP)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    cyc         = 0;
    reset       = 1'b1;
    frame_valid = 1'b0;
    frame_data  = '0;
    brightness  = 2'd3;
    blink_mask  = '0;
    lz_suppress = 1'b0;

    repeat (3) tick();
    chk("rst_an",     32'(AN),          32'hF);
    chk("rst_sseg",   32'(sseg),        32'h7F);
    chk("rst_dp",     32'(DP),          32'h1);
    chk("rst_ready",  32'(frame_ready), 32'h0);
    chk("rst_fstart", 32'(frame_start), 32'h0);

    release_reset();
    chk("rel_ready",  32'(frame_ready), 32'h1);
    chk("rel_fstart", 32'(frame_start), 32'h1);

    // Frame 1: digits 3..0 = 4,3,2,1, all enabled, no dots
    frame_data  = {6'h28, 6'h26, 6'h24, 6'h22};
    frame_valid = 1'b1;
    tick();
    chk("cap_ready_low", 32'(frame_ready), 32'h0);
    frame_valid = 1'b0;
    wait_to(2);
    chk("fstart_off", 32'(frame_start), 32'h0);

    // Offer all-9s while shadow is full: must be ignored
    wait_to(5);
    frame_data  = {4{6'h32}};
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;

    wait_to(39);
    chk("pend_ready", 32'(frame_ready), 32'h0);
    wait_to(40);
    chk("pre_swap_dark", 32'(AN),          32'hF);
    chk("swap_ready",    32'(frame_ready), 32'h1);
    chk("fstart_f1",     32'(frame_start), 32'h1);
    wait_to(41);
    chk("guard_an",   32'(AN),          32'hF);
    chk("guard_sseg", 32'(sseg),        32'h7F);
    chk("fstart_off2", 32'(frame_start), 32'h0);
    wait_to(42);
    chk("d0_an",   32'(AN),   32'hE);
    chk("d0_sseg", 32'(sseg), 32'h79);
    chk("d0_dp",   32'(DP),   32'h1);

    // Frame 2 (digits 3..0 = 0,0,5,0) accepted while frame 1 is displayed
    wait_to(45);
    frame_data  = {6'h20, 6'h20, 6'h2A, 6'h20};
    frame_valid = 1'b1;
    lz_suppress = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("cap2_ready_low", 32'(frame_ready), 32'h0);

    wait_to(50); chk("d0_last",  32'(AN), 32'hE);
    wait_to(51); chk("d1_guard", 32'(AN), 32'hF);
    wait_to(52); chk("d1_an", 32'(AN), 32'hD); chk("d1_sseg", 32'(sseg), 32'h24);
    wait_to(62); chk("d2_an", 32'(AN), 32'hB); chk("d2_sseg", 32'(sseg), 32'h30);
    wait_to(72); chk("d3_an", 32'(AN), 32'h7); chk("d3_sseg", 32'(sseg), 32'h19);

    // Leading-zero suppression on frame 2
    wait_to(82);  chk("lz_d0_an", 32'(AN), 32'hE); chk("lz_d0_sseg", 32'(sseg), 32'h40);
    wait_to(92);  chk("lz_d1_an", 32'(AN), 32'hD); chk("lz_d1_sseg", 32'(sseg), 32'h12);
    wait_to(102); chk("lz_d2_dark", 32'(AN), 32'hF);
    wait_to(112); chk("lz_d3_dark", 32'(AN), 32'hF);
    wait_to(140);
    lz_suppress = 1'b0;
    wait_to(152); chk("nolz_d3_an", 32'(AN), 32'h7); chk("nolz_d3_sseg", 32'(sseg), 32'h40);

    // PWM at brightness 1: lit only at dwell 1,4,7
    wait_to(160);
    brightness = 2'd1;
    wait_to(162); chk("pwm_d1", 32'(AN), 32'hE);
    wait_to(163); chk("pwm_d2", 32'(AN), 32'hF);
    wait_to(165); chk("pwm_d4", 32'(AN), 32'hE);
    wait_to(166); chk("pwm_d5", 32'(AN), 32'hF);
    wait_to(168); chk("pwm_d7", 32'(AN), 32'hE);
    wait_to(170); chk("pwm_d9", 32'(AN), 32'hF);
    brightness = 2'd0;
    wait_to(172); chk("dark_a", 32'(AN), 32'hF);
    wait_to(175); chk("dark_b", 32'(AN), 32'hF);
    wait_to(180);
    brightness = 2'd3;
    blink_mask = 4'b0001;

    // Blink: phase 0 for 200..299, phase 1 for 300..399, phase 0 from 400
    wait_to(202); chk("blink_ph0",    32'(AN), 32'hE);
    wait_to(322); chk("blink_ph1",    32'(AN), 32'hF);
    wait_to(332); chk("blink_other",  32'(AN), 32'hD);
    wait_to(402); chk("blink_ph0_b",  32'(AN), 32'hE);

    // Fill shadow, then reset at dwell 5 of digit 2
    wait_to(405);
    frame_data  = {4{6'h30}};
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("cap3_ready_low", 32'(frame_ready), 32'h0);
    wait_to(425);
    chk("pre_rst_d2", 32'(AN), 32'hB);
    reset = 1'b1;
    tick();
    chk("mid_rst_an",     32'(AN),          32'hF);
    chk("mid_rst_sseg",   32'(sseg),        32'h7F);
    chk("mid_rst_ready",  32'(frame_ready), 32'h0);
    chk("mid_rst_fstart", 32'(frame_start), 32'h0);
    tick();
    blink_mask = '0;
    release_reset();
    chk("rel2_ready",  32'(frame_ready), 32'h1);
    chk("rel2_fstart", 32'(frame_start), 32'h1);
    wait_to(2);  chk("rel2_dark",  32'(AN), 32'hF);
    wait_to(30); chk("rel2_fs30",  32'(frame_start), 32'h0);
    wait_to(40); chk("rel2_fs40",  32'(frame_start), 32'h1);
    wait_to(42); chk("shadow_dropped", 32'(AN), 32'hF);

    // Frame 4 with dot on digit 0 confirms scan order after reset
    frame_data  = {6'h28, 6'h26, 6'h24, 6'h23};
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    wait_to(82);
    chk("f4_d0_an", 32'(AN), 32'hE); chk("f4_d0_sseg", 32'(sseg), 32'h79); chk("f4_d0_dp", 32'(DP), 32'h0);
    wait_to(92);
    chk("f4_d1_an", 32'(AN), 32'hD); chk("f4_d1_sseg", 32'(sseg), 32'h24); chk("f4_d1_dp", 32'(DP), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
